// File: rtl/branch_resolve_unit_if.sv
// Bus bundle for branch_resolve_unit: resolve inputs, fetch lookup and the
// registered results. The BRANCH_STATS_EN macro adds the branch/miss counters.
interface branch_resolve_unit_if #(
    parameter int ADDR_W = 32
);
    logic              branch;
    logic [2:0]        cond;
    logic              zero;
    logic              negative;
    logic [ADDR_W-1:0] pc;
    logic              predicted;
    logic [ADDR_W-1:0] lookup_pc;
    logic              controleMux;
    logic              predict_taken;
    logic              taken_q;
    logic              mispredict;
`ifdef BRANCH_STATS_EN
    logic [15:0]       branch_count;
    logic [15:0]       miss_count;
`endif

    modport master (
        output branch, cond, zero, negative, pc, predicted, lookup_pc,
`ifdef BRANCH_STATS_EN
        input  branch_count, miss_count,
`endif
        input  controleMux, predict_taken, taken_q, mispredict
    );

    modport slave (
        input  branch, cond, zero, negative, pc, predicted, lookup_pc,
`ifdef BRANCH_STATS_EN
        output branch_count, miss_count,
`endif
        output controleMux, predict_taken, taken_q, mispredict
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch condition resolver with a 2-bit saturating-counter BHT for fetch prediction.
// Optional BRANCH_STATS_EN macro adds saturating branch/mispredict counters.
module branch_resolve_unit #(
    parameter int ADDR_W    = 32,
    parameter int BHT_DEPTH = 16,
    parameter int IDX_LSB   = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    branch_resolve_unit_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    function automatic logic decode_cond(input logic [2:0] c,
                                         input logic z,
                                         input logic n);
        logic t;
        t = 1'b0;
        case (c)
            3'b000:  t = z;
            3'b001:  t = ~z;
            3'b010:  t = z | n;
            3'b011:  t = ~z & ~n;
            3'b100:  t = n;
            3'b101:  t = ~n;
            3'b110:  t = 1'b1;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic logic [1:0] sat_step(input logic [1:0] ctr,
                                            input logic up);
        logic [1:0] r;
        r = ctr;
        if (up && ctr != 2'b11)
            r = ctr + 2'd1;
        else if (!up && ctr != 2'b00)
            r = ctr - 2'd1;
        return r;
    endfunction

    logic [1:0]       bht [BHT_DEPTH];
    logic             taken;
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] lk_idx;
    logic             taken_q_p1;
    logic             mispredict_p1;

    // Resolve stage: pure combinational decode; branch gating keeps an
    // unknown cond from reaching controleMux when no branch is present.
    always_comb begin
        taken   = decode_cond(bus.cond, bus.zero, bus.negative);
        upd_idx = bus.pc[IDX_LSB +: IDX_W];
        lk_idx  = bus.lookup_pc[IDX_LSB +: IDX_W];
    end

    assign bus.controleMux   = bus.branch & taken & reset;
    assign bus.predict_taken = bht[lk_idx][1];

    // Update stage: outcome, mispredict flag and counter training.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < BHT_DEPTH; i++)
                bht[i] <= 2'b01;
            taken_q_p1    <= 1'b0;
            mispredict_p1 <= 1'b0;
        end else begin
            mispredict_p1 <= 1'b0;
            if (bus.branch) begin
                taken_q_p1    <= taken;
                mispredict_p1 <= bus.predicted ^ taken;
                bht[upd_idx]  <= sat_step(bht[upd_idx], taken);
            end
        end
    end

    assign bus.taken_q    = taken_q_p1;
    assign bus.mispredict = mispredict_p1;

`ifdef BRANCH_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] branch_count_p1;
    logic [15:0] miss_count_p1;

    always_ff @(posedge clock) begin
        if (!reset) begin
            branch_count_p1 <= 16'd0;
            miss_count_p1   <= 16'd0;
        end else if (bus.branch) begin
            branch_count_p1 <= sat_inc16(branch_count_p1);
            if (bus.predicted != taken)
                miss_count_p1 <= sat_inc16(miss_count_p1);
        end
    end

    assign bus.branch_count = branch_count_p1;
    assign bus.miss_count   = miss_count_p1;
`endif
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised successor to the single-gate branch decision in the MIPS datapath.
- Resolves eight branch conditions from ALU flags and drives the PC mux select.
- Holds a BHT (branch history table) of 2-bit saturating counters indexed by PC bits, so fetch can predict taken/not-taken.
- Reports a registered mispredict flag one cycle after each resolved branch.

Parameters:
- ADDR_W, 32, width of PC inputs.
- BHT_DEPTH, 16, number of 2-bit counters; power of 2, range 2..256.
- IDX_LSB, 2, lowest PC bit used for the BHT index. Index = pc[IDX_LSB + log2(BHT_DEPTH) - 1 : IDX_LSB].

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- branch  in  1  current instruction is a conditional branch.
- cond  in  3  condition code, see Behaviour.
- zero  in  1  ALU zero flag.
- negative  in  1  ALU result sign bit.
- pc  in  ADDR_W  PC of the resolving branch.
- predicted  in  1  prediction fetch used for this branch.
- lookup_pc  in  ADDR_W  fetch-stage PC for prediction.
- controleMux  out  1  PC source select: 1 = branch target. Combinational.
- predict_taken  out  1  prediction for lookup_pc. Combinational.
- taken_q  out  1  registered resolved outcome of the last branch.
- mispredict  out  1  registered; 1 for one cycle after a mispredicted branch.

Behaviour:
- Condition decode (cond -> taken):
  - 000 beq: zero.
  - 001 bne: !zero.
  - 010 blez: zero | negative.
  - 011 bgtz: !zero & !negative.
  - 100 bltz: negative.
  - 101 bgez: !negative.
  - 110: always taken.
  - 111: never taken.
- controleMux = branch & taken & reset. It is forced 0 while reset is low and is 0 whenever branch = 0, regardless of cond and flags.
- predict_taken = MSB of BHT[index(lookup_pc)]. Pure combinational read of current state.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Clock edge with reset = 0:
  - All BHT entries become 01.
  - taken_q = 0, mispredict = 0.
  - Any branch presented in that cycle is discarded: no update, no flag.
- Clock edge with reset = 1 and branch = 1:
  - taken_q <= taken.
  - mispredict <= (predicted != taken).
  - BHT[index(pc)] increments if taken, else decrements.
  - Counters saturate: 11 stays 11 on taken, 00 stays 00 on not-taken.
- Clock edge with reset = 1 and branch = 0:
  - taken_q holds.
  - mispredict <= 0.
  - BHT unchanged.
- Latency: controleMux has 0 cycles; taken_q, mispredict and the BHT update have 1 cycle.
- Same-index lookup and update in one cycle: predict_taken shows the pre-update value (read-before-write). The new value is visible the cycle after the edge.
- PC bits above or below the index field are ignored; aliased PCs share a counter.
- cond is ignored when branch = 0. X on cond with branch = 0 must not propagate to any output.
- Back-to-back branches: each cycle's update is independent and applied in order. There is no stall or handshake; the unit accepts one branch per cycle.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined, adds two outputs:
  - branch_count [15:0]: increments on every accepted branch.
  - miss_count [15:0]: increments on every mispredict.
  - Both are registered, saturate at 16'hFFFF and clear on reset.
  - A branch accepted in the same cycle as reset is not counted.
- Not defined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- After reset, lookup_pc = 0x0000_0040 -> predict_taken = 0. Cycle reset low with branch = 1, cond = 110 -> no BHT change, mispredict = 0, controleMux = 0.
- Condition sweep, each case branch = 1 and checking controleMux combinationally:
  - cond = 000, zero = 1 -> controleMux = 1.
  - cond = 001, zero = 1 -> 0.
  - cond = 011, zero = 0, negative = 0 -> 1.
  - cond = 100, negative = 1 -> 1.
  - cond = 111 with any flags -> 0.
  - branch = 0 with every cond -> 0.
- Training: pc = 0x40, cond = 110, predicted = 0, 3 consecutive cycles.
  - Cycle+1: mispredict = 1, taken_q = 1.
  - Counter path 01 -> 10 -> 11 -> 11 (saturated).
  - Then lookup_pc = 0x40 -> predict_taken = 1.
- Saturation at zero: pc = 0x44, cond = 111, 3 branches -> counter 00. One taken branch -> 01, predict_taken still 0.
- Aliasing and read-before-write, BHT_DEPTH = 16:
  - pc = 0x40 and pc = 0x80 share index 0; training 0x40 changes the prediction for 0x80.
  - Update pc = 0x40 taken while lookup_pc = 0x40 in the same cycle -> predict_taken shows the old value that cycle and the new value next cycle.
- BRANCH_STATS_EN defined: 5 branches with 2 mispredicts -> branch_count = 5, miss_count = 2. Mid-run reset -> both 0 on the next edge.
